// File: rtl/compara_tiros_e_asteroides_pkg.sv
// Shared encodings for the asteroid/shot comparison unit: FSM state codes and RAM word layouts.
// Asteroid word = {loaded, destruido, x, y}; shot word = {loaded, x, y}; y occupies the low bits.
package compara_tiros_e_asteroides_pkg;

  localparam int N_ASTEROIDES_DEF = 16;
  localparam int N_TIROS_DEF      = 4;
  localparam int COORD_W_DEF      = 4;
  localparam int ESTADO_W         = 5;

  typedef enum logic [ESTADO_W-1:0] {
    INICIO     = 5'd0,
    ESPERA     = 5'd1,
    ZERA_AST   = 5'd2,
    LE_AST     = 5'd3,
    AVALIA_AST = 5'd4,
    ZERA_TIRO  = 5'd5,
    LE_TIRO    = 5'd6,
    COMPARA    = 5'd7,
    DESTROI    = 5'd8,
    PROX_TIRO  = 5'd9,
    PROX_AST   = 5'd10,
    FIM        = 5'd11
  } estado_t;

  function automatic int ast_w(input int cw);
    return 2 + 2 * cw;
  endfunction

  function automatic int tiro_w(input int cw);
    return 1 + 2 * cw;
  endfunction

  function automatic int pos_w(input int cw);
    return 2 * cw;
  endfunction

  function automatic int ast_loaded_bit(input int cw);
    return 2 * cw + 1;
  endfunction

  function automatic int ast_destruido_bit(input int cw);
    return 2 * cw;
  endfunction

  function automatic int tiro_loaded_bit(input int cw);
    return 2 * cw;
  endfunction

  function automatic int x_lsb(input int cw);
    return cw;
  endfunction

endpackage

// File: rtl/compara_tiros_e_asteroides_fd.sv
// Datapath: asteroid/shot counters (RAM addresses), asteroid position latch, match compare, write data.
module fd_compara_tiros_e_asteroides
  import compara_tiros_e_asteroides_pkg::*;
#(
  parameter  int N_ASTEROIDES = N_ASTEROIDES_DEF,
  parameter  int N_TIROS      = N_TIROS_DEF,
  parameter  int COORD_W      = COORD_W_DEF,
  localparam int AA_W         = $clog2(N_ASTEROIDES),
  localparam int AT_W         = $clog2(N_TIROS),
  localparam int AST_W        = ast_w(COORD_W),
  localparam int TIRO_W       = tiro_w(COORD_W),
  localparam int POS_W        = pos_w(COORD_W)
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_zera_ia,
  input  logic              i_conta_ia,
  input  logic              i_carrega_ast,
  input  logic              i_zera_it,
  input  logic              i_conta_it,
  input  logic              i_destroi,
  input  logic [AST_W-1:0]  i_dados_asteroide,
  input  logic [TIRO_W-1:0] i_dados_tiro,
  output logic [AA_W-1:0]   o_endereco_asteroide,
  output logic [AT_W-1:0]   o_endereco_tiro,
  output logic [AST_W-1:0]  o_dado_escrita_asteroide,
  output logic [TIRO_W-1:0] o_dado_escrita_tiro,
  output logic              o_ultimo_ast,
  output logic              o_ultimo_tiro,
  output logic              o_ast_vivo,
  output logic              o_acerto
);

  localparam int A_LOADED    = ast_loaded_bit(COORD_W);
  localparam int A_DESTRUIDO = ast_destruido_bit(COORD_W);
  localparam int T_LOADED    = tiro_loaded_bit(COORD_W);

  logic [AA_W-1:0]  r_ia;
  logic [AT_W-1:0]  r_it;
  logic [POS_W-1:0] r_pos_ast;
  logic [POS_W-1:0] w_pos_tiro;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_ia      <= '0;
      r_it      <= '0;
      r_pos_ast <= '0;
    end else begin
      if (i_zera_ia)
        r_ia <= '0;
      else if (i_conta_ia)
        r_ia <= r_ia + 1'b1;
      if (i_zera_it)
        r_it <= '0;
      else if (i_conta_it)
        r_it <= r_it + 1'b1;
      if (i_carrega_ast)
        r_pos_ast <= i_dados_asteroide[POS_W-1:0];
    end
  end

  assign w_pos_tiro    = i_dados_tiro[POS_W-1:0];

  assign o_ultimo_ast  = (r_ia == AA_W'(N_ASTEROIDES - 1));
  assign o_ultimo_tiro = (r_it == AT_W'(N_TIROS - 1));

  // Liveness is judged on the word arriving this cycle, the same word being latched.
  assign o_ast_vivo    = i_dados_asteroide[A_LOADED] && !i_dados_asteroide[A_DESTRUIDO];
  assign o_acerto      = i_dados_tiro[T_LOADED] && (w_pos_tiro == r_pos_ast);

  assign o_endereco_asteroide = r_ia;
  assign o_endereco_tiro      = r_it;

  // Write data is held at zero outside DESTROI so idle outputs stay quiet.
  assign o_dado_escrita_asteroide = i_destroi ? {1'b0, 1'b1, r_pos_ast} : '0;
  assign o_dado_escrita_tiro      = i_destroi ? {1'b0, w_pos_tiro} : '0;

endmodule

// File: rtl/compara_tiros_e_asteroides_uc.sv
// Control unit: sequences the asteroid x shot scan and drives the registered port strobes.
//   state      | meaning
//   INICIO     | post-reset, idle
//   ESPERA     | wait for start request
//   ZERA_AST   | clear asteroid counter
//   LE_AST     | asteroid address presented to RAM
//   AVALIA_AST | latch asteroid, decide if it is alive
//   ZERA_TIRO  | clear shot counter
//   LE_TIRO    | shot address presented to RAM
//   COMPARA    | compare shot against latched asteroid
//   DESTROI    | write both RAMs, score pulse
//   PROX_TIRO  | advance shot or give up on asteroid
//   PROX_AST   | advance asteroid or finish
//   FIM        | done pulse
module uc_compara_tiros_e_asteroides
  import compara_tiros_e_asteroides_pkg::*;
(
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_iniciar,
  input  logic                i_ultimo_ast,
  input  logic                i_ultimo_tiro,
  input  logic                i_ast_vivo,
  input  logic                i_acerto,
  output logic                o_zera_ia,
  output logic                o_conta_ia,
  output logic                o_carrega_ast,
  output logic                o_zera_it,
  output logic                o_conta_it,
  output logic                o_destroi,
  output logic                o_we_asteroide,
  output logic                o_we_tiro,
  output logic                o_pulso_acerto,
  output logic                o_ocupado,
  output logic                o_fim,
  output logic [ESTADO_W-1:0] o_db_estado
);

  estado_t             r_estado;
  estado_t             w_prox;
  logic [ESTADO_W-1:0] w_db;
  logic                r_we_asteroide;
  logic                r_we_tiro;
  logic                r_pulso_acerto;
  logic                r_ocupado;
  logic                r_fim;

  always_comb begin
    w_prox = INICIO;
    w_db   = r_estado;
    case (r_estado)
      INICIO:     w_prox = ESPERA;
      ESPERA:     w_prox = i_iniciar ? ZERA_AST : ESPERA;
      ZERA_AST:   w_prox = LE_AST;
      LE_AST:     w_prox = AVALIA_AST;
      AVALIA_AST: w_prox = i_ast_vivo ? ZERA_TIRO : PROX_AST;
      ZERA_TIRO:  w_prox = LE_TIRO;
      LE_TIRO:    w_prox = COMPARA;
      COMPARA:    w_prox = i_acerto ? DESTROI : PROX_TIRO;
      DESTROI:    w_prox = PROX_AST;
      PROX_TIRO:  w_prox = i_ultimo_tiro ? PROX_AST : LE_TIRO;
      PROX_AST:   w_prox = i_ultimo_ast ? FIM : LE_AST;
      FIM:        w_prox = ESPERA;
      default: begin
        w_prox = INICIO;
        w_db   = '0;
      end
    endcase
  end

  // Port strobes are registered from the next state so they line up with the state they belong to.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_estado       <= INICIO;
      r_we_asteroide <= 1'b0;
      r_we_tiro      <= 1'b0;
      r_pulso_acerto <= 1'b0;
      r_ocupado      <= 1'b0;
      r_fim          <= 1'b0;
    end else begin
      r_estado       <= w_prox;
      r_we_asteroide <= (w_prox == DESTROI);
      r_we_tiro      <= (w_prox == DESTROI);
      r_pulso_acerto <= (w_prox == DESTROI);
      r_ocupado      <= (w_prox != INICIO) && (w_prox != ESPERA);
      r_fim          <= (w_prox == FIM);
    end
  end

  // Datapath controls are decoded straight from the current state; end tests are equality compares.
  assign o_zera_ia      = (r_estado == ZERA_AST);
  assign o_conta_ia     = (r_estado == PROX_AST) && !i_ultimo_ast;
  assign o_carrega_ast  = (r_estado == AVALIA_AST);
  assign o_zera_it      = (r_estado == ZERA_TIRO);
  assign o_conta_it     = (r_estado == PROX_TIRO) && !i_ultimo_tiro;
  assign o_destroi      = (r_estado == DESTROI);

  assign o_we_asteroide = r_we_asteroide;
  assign o_we_tiro      = r_we_tiro;
  assign o_pulso_acerto = r_pulso_acerto;
  assign o_ocupado      = r_ocupado;
  assign o_fim          = r_fim;
  assign o_db_estado    = w_db;

endmodule

// File: rtl/compara_tiros_e_asteroides.sv
// Top level: scans all asteroids against all shots, destroying matches and unloading the shot used.
module compara_tiros_e_asteroides
  import compara_tiros_e_asteroides_pkg::*;
#(
  parameter  int N_ASTEROIDES = N_ASTEROIDES_DEF,
  parameter  int N_TIROS      = N_TIROS_DEF,
  parameter  int COORD_W      = COORD_W_DEF,
  localparam int AA_W         = $clog2(N_ASTEROIDES),
  localparam int AT_W         = $clog2(N_TIROS),
  localparam int AST_W        = ast_w(COORD_W),
  localparam int TIRO_W       = tiro_w(COORD_W)
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_iniciar_compara_tiros_e_asteroides,
  input  logic [AST_W-1:0]    i_dados_asteroide,
  input  logic [TIRO_W-1:0]   i_dados_tiro,
  output logic [AA_W-1:0]     o_endereco_asteroide,
  output logic [AT_W-1:0]     o_endereco_tiro,
  output logic                o_we_asteroide,
  output logic [AST_W-1:0]    o_dado_escrita_asteroide,
  output logic                o_we_tiro,
  output logic [TIRO_W-1:0]   o_dado_escrita_tiro,
  output logic                o_pulso_acerto,
  output logic                o_ocupado,
  output logic                o_fim_compara_tiros_e_asteroides,
  output logic [ESTADO_W-1:0] o_db_estado_compara_tiros_e_asteroides
);

  logic w_zera_ia;
  logic w_conta_ia;
  logic w_carrega_ast;
  logic w_zera_it;
  logic w_conta_it;
  logic w_destroi;
  logic w_ultimo_ast;
  logic w_ultimo_tiro;
  logic w_ast_vivo;
  logic w_acerto;

  uc_compara_tiros_e_asteroides u_uc (
    .i_clock        (i_clock),
    .i_reset        (i_reset),
    .i_iniciar      (i_iniciar_compara_tiros_e_asteroides),
    .i_ultimo_ast   (w_ultimo_ast),
    .i_ultimo_tiro  (w_ultimo_tiro),
    .i_ast_vivo     (w_ast_vivo),
    .i_acerto       (w_acerto),
    .o_zera_ia      (w_zera_ia),
    .o_conta_ia     (w_conta_ia),
    .o_carrega_ast  (w_carrega_ast),
    .o_zera_it      (w_zera_it),
    .o_conta_it     (w_conta_it),
    .o_destroi      (w_destroi),
    .o_we_asteroide (o_we_asteroide),
    .o_we_tiro      (o_we_tiro),
    .o_pulso_acerto (o_pulso_acerto),
    .o_ocupado      (o_ocupado),
    .o_fim          (o_fim_compara_tiros_e_asteroides),
    .o_db_estado    (o_db_estado_compara_tiros_e_asteroides)
  );

  fd_compara_tiros_e_asteroides #(
    .N_ASTEROIDES (N_ASTEROIDES),
    .N_TIROS      (N_TIROS),
    .COORD_W      (COORD_W)
  ) u_fd (
    .i_clock                  (i_clock),
    .i_reset                  (i_reset),
    .i_zera_ia                (w_zera_ia),
    .i_conta_ia               (w_conta_ia),
    .i_carrega_ast            (w_carrega_ast),
    .i_zera_it                (w_zera_it),
    .i_conta_it               (w_conta_it),
    .i_destroi                (w_destroi),
    .i_dados_asteroide        (i_dados_asteroide),
    .i_dados_tiro             (i_dados_tiro),
    .o_endereco_asteroide     (o_endereco_asteroide),
    .o_endereco_tiro          (o_endereco_tiro),
    .o_dado_escrita_asteroide (o_dado_escrita_asteroide),
    .o_dado_escrita_tiro      (o_dado_escrita_tiro),
    .o_ultimo_ast             (w_ultimo_ast),
    .o_ultimo_tiro            (w_ultimo_tiro),
    .o_ast_vivo               (w_ast_vivo),
    .o_acerto                 (w_acerto)
  );

endmodule

// File: doc/compara_tiros_e_asteroides.md
Name: compara_tiros_e_asteroides

Overview:
Downstream stage of the asteroid/ship comparison control unit. When started, it scans every asteroid slot against every shot slot. On each position match it marks the asteroid destroyed, unloads the shot, and pulses a score event. Reads and writes go through the asteroid and shot RAMs (1-cycle synchronous read latency). It signals completion with a one-cycle done pulse.

Parameters:
N_ASTEROIDES, 16, number of asteroid slots (power of 2, >=2)
N_TIROS, 4, number of shot slots (power of 2, >=2)
COORD_W, 4, width of each coordinate (x, y)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
iniciar_compara_tiros_e_asteroides  in  1  start request, sampled only in ESPERA
dados_asteroide  in  2+2*COORD_W  asteroid RAM read data {loaded, destruido, x, y}
dados_tiro  in  1+2*COORD_W  shot RAM read data {loaded, x, y}
endereco_asteroide  out  clog2(N_ASTEROIDES)  asteroid RAM address = asteroid counter
endereco_tiro  out  clog2(N_TIROS)  shot RAM address = shot counter
we_asteroide  out  1  asteroid RAM write enable
dado_escrita_asteroide  out  2+2*COORD_W  {0, 1, x, y} of the latched asteroid
we_tiro  out  1  shot RAM write enable
dado_escrita_tiro  out  1+2*COORD_W  {0, x, y} of the current shot
pulso_acerto  out  1  one-cycle pulse per destruction (score increment)
ocupado  out  1  high in every state except INICIO/ESPERA
fim_compara_tiros_e_asteroides  out  1  one-cycle done pulse
db_estado_compara_tiros_e_asteroides  out  5  current state code

Behaviour:
- Reset: state INICIO; both counters and the latched asteroid register = 0; all outputs 0. Reset mid-scan aborts immediately with no further writes; partial writes already made persist.
- Moore FSM (codes):
  - INICIO(0) -> ESPERA.
  - ESPERA(1): iniciar=1 -> ZERA_AST, else stay.
  - ZERA_AST(2): ia<=0 -> LE_AST.
  - LE_AST(3): address = ia; RAM data is valid next cycle -> AVALIA_AST.
  - AVALIA_AST(4): latch dados_asteroide. If loaded=1 && destruido=0 -> ZERA_TIRO, else PROX_AST.
  - ZERA_TIRO(5): it<=0 -> LE_TIRO.
  - LE_TIRO(6) -> COMPARA.
  - COMPARA(7): if dados_tiro.loaded=1 && x,y equal latched x,y -> DESTROI, else PROX_TIRO.
  - DESTROI(8): we_asteroide=1, we_tiro=1, pulso_acerto=1 -> PROX_AST. Scanning of the current asteroid stops here.
  - PROX_TIRO(9): it==N_TIROS-1 -> PROX_AST, else it++ -> LE_TIRO.
  - PROX_AST(10): ia==N_ASTEROIDES-1 -> FIM, else ia++ -> LE_AST.
  - FIM(11): fim=1 -> ESPERA.
  - Unused codes -> INICIO, db=0.
- Counters wrap naturally, but the end test uses an equality compare, never the carry-out.
- Write data is formed combinationally from the latched asteroid and the live dados_tiro in DESTROI.
- Only the lowest-index matching shot is consumed per asteroid.
- A consumed shot is re-read as unloaded by later asteroids (its write occurs several cycles earlier), so one shot destroys at most one asteroid.
- iniciar while ocupado=1 is ignored. iniciar held high through FIM restarts a scan on the cycle after ESPERA.
- Latency with no live asteroids: fim asserted 2+3*N_ASTEROIDES cycles after the ESPERA cycle that sampled iniciar (50 for N=16).
- Each live asteroid that is not hit adds 1+3*N_TIROS cycles.

Decomposition:
- Shared package: state encodings, field offsets/widths of the asteroid and shot words, and the LOADED/DESTRUIDO bit positions (reused by the upstream unit and the RAM init).
- Split into uc_compara_tiros_e_asteroides (FSM, outputs, db_estado) and fd_compara_tiros_e_asteroides (two counters, asteroid latch, comparator, write-data muxing). The top level instantiates both.

Test Plan:
- All slots unloaded, iniciar pulse -> fim pulse exactly 50 cycles later; we_* and pulso_acerto never high.
- Asteroid 3 {1,0,5,7}, shot 1 {1,5,7} -> one DESTROI: asteroid[3]={0,1,5,7}, shot[1]={0,5,7}, pulso_acerto high for exactly one cycle.
- Shots 0 and 2 both at (5,7), asteroid 3 at (5,7) -> only shot 0 unloaded; shot 2 stays loaded.
- Asteroids 2 and 9 at (4,4), one shot at (4,4) -> asteroid 2 destroyed; asteroid 9 untouched; one acerto pulse.
- Asteroid with destruido=1 at a shot's position -> no write; shot stays loaded.
- reset asserted in COMPARA -> db=0 next cycle, no writes, no fim. A new iniciar then completes normally. iniciar pulsed mid-scan -> exactly one fim pulse.
